// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: controller state encoding and
// algorithm selector values.
package gcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int GCD_SUB = 0;
   localparam int GCD_BIN = 1;

endpackage

// File: rtl/gcd_step.sv
// One combinational iteration of the GCD reduction for the selected
// algorithm: next A/B/K plus the equality and ordering flags.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MODE  = GCD_SUB,
   parameter int K_W   = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [K_W-1:0]   k,
   output logic [WIDTH-1:0] a_nxt,
   output logic [WIDTH-1:0] b_nxt,
   output logic [K_W-1:0]   k_nxt,
   output logic             eq,
   output logic             a_gt
);

   logic [WIDTH-1:0] diff_ab;
   logic [WIDTH-1:0] diff_ba;

   // Differences are only consumed when the minuend is strictly larger.
   always_comb begin
      diff_ab = a - b;
      diff_ba = b - a;
   end

   // Reduction step; the caller only commits it while a != b.
   always_comb begin
      eq    = (a == b);
      a_gt  = (a > b);
      a_nxt = a;
      b_nxt = b;
      k_nxt = k;
      if (MODE == GCD_SUB) begin
         if (a_gt) begin
            a_nxt = diff_ab;
         end else if (!eq) begin
            b_nxt = diff_ba;
         end
      end else begin
         if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            k_nxt = k + K_W'(1);
         end else if (!a[0]) begin
            a_nxt = a >> 1;
         end else if (!b[0]) begin
            b_nxt = b >> 1;
         end else if (a_gt) begin
            a_nxt = diff_ab >> 1;
         end else begin
            b_nxt = diff_ba >> 1;
         end
      end
   end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine: IDLE/CALC/DONE controller with valid/ready handshakes,
// operand zero check and a saturating iteration counter.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MODE  = GCD_SUB,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_gcd,
   output logic             out_err,
   output logic [CNT_W-1:0] out_cycles
);

   localparam int K_W = $clog2(WIDTH) + 1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [K_W-1:0]   k;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0] a_nxt;
   logic [WIDTH-1:0] b_nxt;
   logic [K_W-1:0]   k_nxt;
   logic             eq;
   logic             a_gt;
   logic             zero_op;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   gcd_step #(
      .WIDTH (WIDTH),
      .MODE  (MODE),
      .K_W   (K_W)
   ) u_step (
      .a     (a),
      .b     (b),
      .k     (k),
      .a_nxt (a_nxt),
      .b_nxt (b_nxt),
      .k_nxt (k_nxt),
      .eq    (eq),
      .a_gt  (a_gt)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid) state_nxt = zero_op ? ST_DONE : ST_CALC;
         ST_CALC: if (eq) state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Combinational control outputs.
   always_comb begin
      in_ready = (state == ST_IDLE);
      zero_op  = (in_a == '0) || (in_b == '0);
      cnt_inc  = sat_inc(cnt);
   end

   // Operand registers, iteration counter and registered results.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a          <= '0;
         b          <= '0;
         k          <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_gcd    <= '0;
         out_err    <= 1'b0;
         out_cycles <= '0;
      end else begin
         out_valid <= (state_nxt == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (zero_op) begin
                     out_err    <= 1'b1;
                     out_gcd    <= '0;
                     out_cycles <= '0;
                  end else begin
                     a   <= in_a;
                     b   <= in_b;
                     k   <= '0;
                     cnt <= '0;
                  end
               end
            end
            ST_CALC: begin
               cnt <= cnt_inc;
               if (eq) begin
                  out_gcd    <= (MODE == GCD_BIN) ? (a << k) : a;
                  out_err    <= 1'b0;
                  out_cycles <= cnt_inc;
               end else begin
                  a <= a_nxt;
                  b <= b_nxt;
                  k <= k_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: three configurations (subtractive, binary, and
// subtractive with a 4-bit counter) driven by directed vectors and checked
// against an arithmetic GCD / iteration-count model.
module tb_gcd_engine;

   logic       clk;
   logic       rst;
   logic [2:0] iv;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       out_ready;

   logic        r0, r1, r2, v0, v1, v2, e0, e1, e2;
   logic [7:0]  g0, g1, g2;
   logic [15:0] c0, c1;
   logic [3:0]  c2;

   int          sel;
   logic        rdy, vld, err;
   logic [7:0]  gcd;
   logic [15:0] cyc;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;
   int exp_gcd, exp_err, exp_cyc;

   gcd_engine #(.WIDTH(8), .MODE(0), .CNT_W(16)) u_sub (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(r0), .in_a(in_a), .in_b(in_b),
      .out_valid(v0), .out_ready(out_ready), .out_gcd(g0), .out_err(e0), .out_cycles(c0));

   gcd_engine #(.WIDTH(8), .MODE(1), .CNT_W(16)) u_bin (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(r1), .in_a(in_a), .in_b(in_b),
      .out_valid(v1), .out_ready(out_ready), .out_gcd(g1), .out_err(e1), .out_cycles(c1));

   gcd_engine #(.WIDTH(8), .MODE(0), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(r2), .in_a(in_a), .in_b(in_b),
      .out_valid(v2), .out_ready(out_ready), .out_gcd(g2), .out_err(e2), .out_cycles(c2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      case (sel)
         1:       begin rdy = r1; vld = v1; gcd = g1; err = e1; cyc = c1; end
         2:       begin rdy = r2; vld = v2; gcd = g2; err = e2; cyc = {12'd0, c2}; end
         default: begin rdy = r0; vld = v0; gcd = g0; err = e0; cyc = c0; end
      endcase
   end

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Result GCD from Euclid by division; iteration count from the algorithm's rules.
   task automatic model(input int mode, input int a, input int b,
                        output int g, output int e, output int iters);
      int x, y, t, q;
      if (a == 0 || b == 0) begin
         g = 0; e = 1; iters = 0;
         return;
      end
      e = 0;
      x = a; y = b; q = 0;
      while (y != 0) begin
         q += x / y;
         t = x % y;
         x = y;
         y = t;
      end
      g = x;
      if (mode == 0) begin
         iters = q;  // q-1 subtractions plus the equality cycle
      end else begin
         x = a; y = b; iters = 0;
         while (iters < 1000) begin
            iters++;
            if (x == y) break;
            if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; end
            else if (x % 2 == 0) x /= 2;
            else if (y % 2 == 0) y /= 2;
            else if (x > y) x = (x - y) / 2;
            else y = (y - x) / 2;
         end
      end
   endtask

   function automatic int sat(input int s, input int it);
      int maxc;
      maxc = (s == 2) ? 15 : 65535;
      return (it > maxc) ? maxc : it;
   endfunction

   function automatic int mode_of(input int s);
      return (s == 1) ? 1 : 0;
   endfunction

   // Every cycle a result is presented, it must match the model.
   always @(negedge clk) begin
      if (chk_en && rst && vld) begin
         chk("out_gcd", int'(gcd), exp_gcd);
         chk("out_err", int'(err), exp_err);
         chk("out_cycles", int'(cyc), exp_cyc);
      end
   end

   task automatic wait_valid(input int exp_lat);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!vld && n < 400);
      chk("latency", n, exp_lat);
   endtask

   task automatic run(input int s, input int a, input int b,
                      input int lg, input int le, input int lc);
      int g, e, it;
      sel = s;
      model(mode_of(s), a, b, g, e, it);
      chk("model_gcd", g, lg);
      chk("model_err", e, le);
      chk("model_cycles", sat(s, it), lc);
      exp_gcd = g; exp_err = e; exp_cyc = sat(s, it);
      @(negedge clk);
      chk("in_ready_idle", int'(rdy), 1);
      in_a = 8'(a); in_b = 8'(b); iv[s] = 1'b1;
      @(posedge clk);
      #1 iv = '0;
      wait_valid(e ? 1 : it + 1);
      @(posedge clk);
      @(negedge clk);
      chk("valid_drop", int'(vld), 0);
      chk("in_ready_after", int'(rdy), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int g, e, it;
      rst = 1'b0; iv = '0; in_a = '0; in_b = '0; out_ready = 1'b1; sel = 0;
      repeat (2) @(negedge clk);
      chk("rst_valid", int'(vld), 0);
      chk("rst_gcd", int'(gcd), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_cycles", int'(cyc), 0);
      chk("rst_in_ready", int'(rdy), 1);
      rst = 1'b1;
      chk_en = 1;

      run(0, 48, 18, 6, 0, 5);
      run(1, 48, 18, 6, 0, 6);
      run(0, 0, 25, 0, 1, 0);
      run(0, 0, 0, 0, 1, 0);
      run(0, 25, 0, 0, 1, 0);
      run(0, 255, 255, 255, 0, 1);
      run(0, 255, 1, 1, 0, 255);
      run(2, 255, 1, 1, 0, 15);
      run(1, 64, 16, 16, 0, 7);
      run(1, 255, 255, 255, 0, 1);
      run(1, 0, 7, 0, 1, 0);

      // Backpressure: result held while a competing operand pair is ignored.
      sel = 0;
      model(0, 12, 8, g, e, it);
      exp_gcd = g; exp_err = e; exp_cyc = it;
      chk("model_bp_gcd", g, 4);
      out_ready = 1'b0;
      @(negedge clk);
      in_a = 8'd12; in_b = 8'd8; iv[0] = 1'b1;
      @(posedge clk);
      #1 iv = '0;
      wait_valid(it + 1);
      in_a = 8'd9; in_b = 8'd6; iv[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", int'(rdy), 0);
         chk("bp_valid", int'(vld), 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      model(0, 9, 6, g, e, it);
      exp_gcd = g; exp_err = e; exp_cyc = it;
      chk("model_96_gcd", g, 3);
      @(negedge clk);
      chk("bp_release_ready", int'(rdy), 1);
      @(posedge clk);
      #1 iv = '0;
      wait_valid(it + 1);
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid_drop", int'(vld), 0);

      // Asynchronous reset in the third CALC cycle of 48,18.
      model(0, 48, 18, g, e, it);
      exp_gcd = g; exp_err = e; exp_cyc = it;
      in_a = 8'd48; in_b = 8'd18; iv[0] = 1'b1;
      @(posedge clk);
      #1 iv = '0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk_en = 0;
      rst = 1'b0;
      #1;
      chk("arst_valid", int'(vld), 0);
      chk("arst_gcd", int'(gcd), 0);
      chk("arst_err", int'(err), 0);
      chk("arst_cycles", int'(cyc), 0);
      chk("arst_in_ready", int'(rdy), 1);
      @(negedge clk);
      rst = 1'b1;
      chk_en = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("arst_no_result", int'(vld), 0);
      end
      run(0, 21, 14, 7, 0, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
